elevator_scheduler: RTL
=======================

# elevator_scheduler

Request scheduler for the single-car elevator datapath. It latches floor calls into a pending mask and serves them in LOOK order, so the car keeps its direction while calls remain ahead. It drives the car's requested-floor input with one target floor at a time and times the door dwell. It sits between the call-button logic and the car position counter, and reads back the car's current floor and stop flag.

## Interface
- NUM_FLOORS, 16, number of served floors (2..51; floors 0..NUM_FLOORS-1)
- FLOOR_W, 6, floor-number width
- DOOR_CYCLES, 8, door dwell in clk cycles (≥2)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- call_req  in  NUM_FLOORS  one-cycle call pulses, bit i = floor i; several bits may be set
- cur_floor  in  FLOOR_W  car position from the car counter
- car_stop  in  1  car reports it is stopped at its requested floor
- target_floor  out  FLOOR_W  floor requested from the car
- pending  out  NUM_FLOORS  unserved calls
- dir_up  out  1  current/last sweep direction (1 = up)
- moving  out  1  state is MOVE_UP or MOVE_DN
- door_open  out  1  state is DOOR
- busy  out  1  pending ≠ 0 or state ≠ IDLE

## Operation
- States: IDLE, MOVE_UP, MOVE_DN, DOOR.
- Pending update each cycle: pending ← (pending | call_req) & ~clr.
  - clr = bit cur_floor while in DOOR, else 0.
  - A call for cur_floor during DOOR never sets pending; it restarts the dwell counter.
- above = any pending bit > cur_floor; below = any pending bit < cur_floor.
- IDLE:
  - pending bit cur_floor set → DOOR.
  - else above or below → pick the nearer call; equal distance → up. Go to MOVE_UP or MOVE_DN.
  - target_floor = cur_floor.
- MOVE_UP: target_floor = lowest pending floor ≥ cur_floor. It is recomputed every cycle, so a new call between the car and the target is picked up.
- MOVE_DN: mirror of MOVE_UP; target_floor = highest pending floor ≤ cur_floor.
- MOVE_x → DOOR when car_stop && cur_floor == target_floor && pending[target_floor].
- DOOR: 4-bit-or-wider down-counter loaded with DOOR_CYCLES-1 on entry and on any restart. On expiry:
  - dir_up && above → MOVE_UP
  - else below → MOVE_DN
  - else above → MOVE_UP
  - else IDLE
- target_floor holds cur_floor throughout DOOR.
- dir_up: set on entry to MOVE_UP, cleared on entry to MOVE_DN, held otherwise.
- cur_floor ≥ NUM_FLOORS is out of range: stay in IDLE or force IDLE, target_floor = 0, pending retained.

## Timing
- Reset (async assert, sync deassert internally): state IDLE, pending 0, target_floor 0, dir_up 1, moving 0, door_open 0, busy 0, dwell counter 0.
- call_req sampled at edge N; pending visible after N. The state/target decision uses registered pending, so MOVE_x and the new target_floor appear after edge N+1.
- DOOR lasts exactly DOOR_CYCLES cycles absent restarts.
- Reset mid-move or mid-dwell discards all calls immediately. The car then sees target 0.
- All outputs are registered; no combinational input→output paths.

## Structure
- Shared package elevator_pkg: state enum, FLOOR_W, MAX_FLOORS = 51.
- One sub-module, floor_search: combinational nearest-set-bit finder. Inputs are the mask and cur_floor; outputs are above/below flags plus the nearest-above and nearest-below floor numbers. The FSM, pending register and dwell counter live in elevator_scheduler.

## Test plan
- Reset with cur_floor = 0, then call_req bit 5 → after 2 edges MOVE_UP, target 5. Car steps to 5 with car_stop → DOOR for 8 cycles, pending[5] cleared, then IDLE.
- Car at 2 moving up to 9; call at floor 4 arrives while cur_floor = 3 → target switches to 4, door at 4, then resumes to 9.
- Car at 6 in IDLE; simultaneous calls at 3 and 9 (equal distance) → MOVE_UP first. After the door at 9, MOVE_DN to 3.
- In DOOR at floor 7, call_req bit 7 pulsed at dwell cycle 5 → pending[7] stays 0 and door_open extends to 5 + 8 cycles total.
- Calls at 1, 10 and 12 pending, then rst_n asserted mid-MOVE_UP → all outputs at reset values on the same cycle. No motion until a new call.
- NUM_FLOORS = 51, call at floor 50 from floor 0 → target 50. A call bit at the top index is served; wrap/overflow never occurs.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and limits for the elevator request scheduler.
package elevator_pkg;

    localparam int unsigned FLOOR_W    = 6;
    localparam int unsigned MAX_FLOORS = 51;

    typedef enum logic [1:0] {
        StIdle,
        StMoveUp,
        StMoveDn,
        StDoor
    } state_e;

endpackage

// File: rtl/elevator_scheduler_floor_search.sv
// Combinational nearest-call finder: lowest set bit above and highest set bit below cur_floor.
module floor_search
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 16,
    parameter int unsigned FLOOR_W    = 6
) (
    input  logic [NUM_FLOORS-1:0] mask,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic                  above,
    output logic                  below,
    output logic [FLOOR_W-1:0]    above_floor,
    output logic [FLOOR_W-1:0]    below_floor
);

    always_comb begin
        above       = 1'b0;
        below       = 1'b0;
        above_floor = '0;
        below_floor = '0;
        // Scan downwards so the last hit is the nearest floor above the car.
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (mask[i] && (FLOOR_W'(i) > cur_floor)) begin
                above       = 1'b1;
                above_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (mask[i] && (FLOOR_W'(i) < cur_floor)) begin
                below       = 1'b1;
                below_floor = FLOOR_W'(i);
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// LOOK-order elevator scheduler: latches calls, picks one target floor at a time, times the door.
module elevator_scheduler #(
    parameter int unsigned NUM_FLOORS  = 16,
    parameter int unsigned FLOOR_W     = 6,
    parameter int unsigned DOOR_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  car_stop,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  busy
);
    import elevator_pkg::*;

    localparam int unsigned CntW = ($clog2(DOOR_CYCLES) < 4) ? 4 : $clog2(DOOR_CYCLES);
    localparam logic [CntW-1:0] DwellLoad = CntW'(DOOR_CYCLES - 1);

    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    state_e                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [FLOOR_W-1:0]      target_q, target_d;
    logic                    dir_q, dir_d;
    logic [CntW-1:0]         cnt_q, cnt_d;

    logic [NUM_FLOORS-1:0]   cur_bit, clr;
    logic                    in_range, pend_at_cur, call_at_cur;
    logic                    above, below;
    logic [FLOOR_W-1:0]      above_floor, below_floor;
    logic [FLOOR_W-1:0]      ge_floor, le_floor, up_dist, dn_dist;

    // Assertion is immediate; release is delayed two clocks to avoid a reset-recovery race.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    floor_search #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_floor_search (
        .mask        (pending_q),
        .cur_floor   (cur_floor),
        .above       (above),
        .below       (below),
        .above_floor (above_floor),
        .below_floor (below_floor)
    );

    // An out-of-range floor shifts the one-hot off the end, yielding an all-zero mask.
    assign cur_bit     = {{(NUM_FLOORS - 1){1'b0}}, 1'b1} << cur_floor;
    assign in_range    = cur_floor < FLOOR_W'(NUM_FLOORS);
    assign pend_at_cur = |(pending_q & cur_bit);
    assign call_at_cur = |(call_req & cur_bit);
    assign ge_floor    = pend_at_cur ? cur_floor : above_floor;
    assign le_floor    = pend_at_cur ? cur_floor : below_floor;
    assign up_dist     = above_floor - cur_floor;
    assign dn_dist     = cur_floor - below_floor;
    assign clr         = (state_q == StDoor) ? cur_bit : '0;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        pending_d = (pending_q | call_req) & ~clr;

        if (!in_range) begin
            state_d  = StIdle;
            target_d = '0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    target_d = cur_floor;
                    if (pend_at_cur) begin
                        state_d = StDoor;
                        cnt_d   = DwellLoad;
                    end else if (above && (!below || (up_dist <= dn_dist))) begin
                        state_d  = StMoveUp;
                        target_d = above_floor;
                    end else if (below) begin
                        state_d  = StMoveDn;
                        target_d = below_floor;
                    end
                end
                StMoveUp: begin
                    if (car_stop && (cur_floor == target_q) && pend_at_cur) begin
                        state_d  = StDoor;
                        target_d = cur_floor;
                        cnt_d    = DwellLoad;
                    end else if (pend_at_cur || above) begin
                        target_d = ge_floor;
                    end
                end
                StMoveDn: begin
                    if (car_stop && (cur_floor == target_q) && pend_at_cur) begin
                        state_d  = StDoor;
                        target_d = cur_floor;
                        cnt_d    = DwellLoad;
                    end else if (pend_at_cur || below) begin
                        target_d = le_floor;
                    end
                end
                StDoor: begin
                    target_d = cur_floor;
                    if (call_at_cur) begin
                        cnt_d = DwellLoad;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (dir_q && above) begin
                        state_d  = StMoveUp;
                        target_d = ge_floor;
                    end else if (below) begin
                        state_d  = StMoveDn;
                        target_d = le_floor;
                    end else if (above) begin
                        state_d  = StMoveUp;
                        target_d = ge_floor;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (state_d == StMoveUp)      dir_d = 1'b1;
        else if (state_d == StMoveDn) dir_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            target_q  <= '0;
            dir_q     <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
        end
    end

    assign target_floor = target_q;
    assign pending      = pending_q;
    assign dir_up       = dir_q;
    assign moving       = (state_q == StMoveUp) || (state_q == StMoveDn);
    assign door_open    = (state_q == StDoor);
    assign busy         = (|pending_q) || (state_q != StIdle);

endmodule
